// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out rename tags, captures CDB results, commits in order and flushes on mispredict.
// Commit outputs are registered (CDB at edge N commits at edge N+1 at the earliest); a full buffer rejects allocation, rdy=0 freezes all state.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_alloc_valid,
  input  logic [REG_W-1:0]     in_alloc_dest_reg,
  input  logic                 in_alloc_is_br,
  input  logic                 in_alloc_pred,
  input  logic [31:0]          in_alloc_pc,
  output logic [ROB_POS_W-1:0] out_alloc_rob,
  output logic                 out_full,
  input  logic                 in_cdb_valid,
  input  logic [ROB_POS_W-1:0] in_cdb_rob,
  input  logic [31:0]          in_cdb_value,
  input  logic                 in_cdb_taken,
  input  logic [31:0]          in_cdb_target,
  input  logic [ROB_POS_W-1:0] in_query_rob1,
  input  logic [ROB_POS_W-1:0] in_query_rob2,
  output logic                 out_query_rdy1,
  output logic                 out_query_rdy2,
  output logic [31:0]          out_query_val1,
  output logic [31:0]          out_query_val2,
  output logic [REG_W-1:0]     out_commit_reg,
  output logic [ROB_POS_W-1:0] out_commit_rob,
  output logic [31:0]          out_commit_value,
  output logic                 out_xbp,
  output logic [31:0]          out_xbp_pc
);
  localparam int CNT_W = ROB_POS_W + 1;

  logic [ROB_SIZE-1:0]  valid_q, valid_d;
  logic [ROB_SIZE-1:0]  ready_q, ready_d;
  logic [ROB_POS_W-1:0] head_q, head_d;
  logic [ROB_POS_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [REG_W-1:0]     commit_reg_q, commit_reg_d;
  logic [ROB_POS_W-1:0] commit_rob_q, commit_rob_d;
  logic [31:0]          commit_value_q, commit_value_d;
  logic                 xbp_q, xbp_d;
  logic [31:0]          xbp_pc_q, xbp_pc_d;

  logic [REG_W-1:0] dest_q   [ROB_SIZE];
  logic             is_br_q  [ROB_SIZE];
  logic             pred_q   [ROB_SIZE];
  logic [31:0]      pc_q     [ROB_SIZE];
  logic [31:0]      value_q  [ROB_SIZE];
  logic             taken_q  [ROB_SIZE];
  logic [31:0]      target_q [ROB_SIZE];

  logic alloc_fire, wb_fire, commit_fire, mispredict;
  logic cdb_hit1, cdb_hit2;

  assign out_full      = (count_q == CNT_W'(ROB_SIZE));
  assign out_alloc_rob = tail_q;

  assign alloc_fire  = rdy && in_alloc_valid && !out_full && !xbp_q;
  assign wb_fire     = rdy && in_cdb_valid && valid_q[in_cdb_rob] && !ready_q[in_cdb_rob] && !xbp_q;
  assign commit_fire = rdy && valid_q[head_q] && ready_q[head_q] && !xbp_q;
  assign mispredict  = commit_fire && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

  // The CDB bypass lets a consumer see a result in the same cycle it is broadcast.
  assign cdb_hit1       = in_cdb_valid && (in_cdb_rob == in_query_rob1);
  assign cdb_hit2       = in_cdb_valid && (in_cdb_rob == in_query_rob2);
  assign out_query_rdy1 = (valid_q[in_query_rob1] && ready_q[in_query_rob1]) || cdb_hit1;
  assign out_query_rdy2 = (valid_q[in_query_rob2] && ready_q[in_query_rob2]) || cdb_hit2;
  assign out_query_val1 = cdb_hit1 ? in_cdb_value : value_q[in_query_rob1];
  assign out_query_val2 = cdb_hit2 ? in_cdb_value : value_q[in_query_rob2];

  assign out_commit_reg   = commit_reg_q;
  assign out_commit_rob   = commit_rob_q;
  assign out_commit_value = commit_value_q;
  assign out_xbp          = xbp_q;
  assign out_xbp_pc       = xbp_pc_q;

  always_comb begin
    valid_d        = valid_q;
    ready_d        = ready_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_reg_d   = '0;
    commit_rob_d   = commit_rob_q;
    commit_value_d = commit_value_q;
    xbp_d          = 1'b0;
    xbp_pc_d       = xbp_pc_q;

    if (wb_fire) ready_d[in_cdb_rob] = 1'b1;

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ROB_POS_W'(1);
      commit_reg_d    = dest_q[head_q];
      commit_rob_d    = head_q;
      commit_value_d  = value_q[head_q];
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + ROB_POS_W'(1);
    end

    if (alloc_fire && !commit_fire)      count_d = count_q + CNT_W'(1);
    else if (commit_fire && !alloc_fire) count_d = count_q - CNT_W'(1);

    // Flush wins over any allocation or writeback landing on the same edge.
    if (mispredict) begin
      xbp_d    = 1'b1;
      xbp_pc_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
      valid_d  = '0;
      ready_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_reg_q   <= '0;
      commit_rob_q   <= '0;
      commit_value_q <= '0;
      xbp_q          <= 1'b0;
      xbp_pc_q       <= '0;
    end else begin
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_reg_q   <= commit_reg_d;
      commit_rob_q   <= commit_rob_d;
      commit_value_q <= commit_value_d;
      xbp_q          <= xbp_d;
      xbp_pc_q       <= xbp_pc_d;
    end
  end

  // Payload is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest_q[tail_q]  <= in_alloc_dest_reg;
      is_br_q[tail_q] <= in_alloc_is_br;
      pred_q[tail_q]  <= in_alloc_pred;
      pc_q[tail_q]    <= in_alloc_pc;
    end
    if (wb_fire) begin
      value_q[in_cdb_rob]  <= in_cdb_value;
      taken_q[in_cdb_rob]  <= in_cdb_taken;
      target_q[in_cdb_rob] <= in_cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order commit, full/wrap, CDB bypass, mispredict flush, freeze.
// Inputs change 1ns after the rising edge; outputs are sampled in the same window.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        in_alloc_valid = 1'b0;
  logic [4:0]  in_alloc_dest_reg = '0;
  logic        in_alloc_is_br = 1'b0;
  logic        in_alloc_pred = 1'b0;
  logic [31:0] in_alloc_pc = '0;
  logic [3:0]  out_alloc_rob;
  logic        out_full;
  logic        in_cdb_valid = 1'b0;
  logic [3:0]  in_cdb_rob = '0;
  logic [31:0] in_cdb_value = '0;
  logic        in_cdb_taken = 1'b0;
  logic [31:0] in_cdb_target = '0;
  logic [3:0]  in_query_rob1 = '0;
  logic [3:0]  in_query_rob2 = '0;
  logic        out_query_rdy1, out_query_rdy2;
  logic [31:0] out_query_val1, out_query_val2;
  logic [4:0]  out_commit_reg;
  logic [3:0]  out_commit_rob;
  logic [31:0] out_commit_value;
  logic        out_xbp;
  logic [31:0] out_xbp_pc;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.ROB_SIZE(16), .ROB_POS_W(4), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_alloc_valid(in_alloc_valid), .in_alloc_dest_reg(in_alloc_dest_reg),
    .in_alloc_is_br(in_alloc_is_br), .in_alloc_pred(in_alloc_pred), .in_alloc_pc(in_alloc_pc),
    .out_alloc_rob(out_alloc_rob), .out_full(out_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_rob(in_cdb_rob), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
    .in_query_rob1(in_query_rob1), .in_query_rob2(in_query_rob2),
    .out_query_rdy1(out_query_rdy1), .out_query_rdy2(out_query_rdy2),
    .out_query_val1(out_query_val1), .out_query_val2(out_query_val2),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value), .out_xbp(out_xbp), .out_xbp_pc(out_xbp_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] d, input logic br, input logic p, input logic [31:0] pc);
    in_alloc_valid = 1'b1; in_alloc_dest_reg = d; in_alloc_is_br = br; in_alloc_pred = p; in_alloc_pc = pc;
    tick();
    in_alloc_valid = 1'b0; in_alloc_is_br = 1'b0; in_alloc_pred = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    in_cdb_valid = 1'b1; in_cdb_rob = t; in_cdb_value = v; in_cdb_taken = tk; in_cdb_target = tg;
    tick();
    in_cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL rst_alloc_rob got=%0d exp=0", out_alloc_rob); end
    total++; if (out_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", out_full); end
    total++; if (out_xbp_pc !== 32'd0) begin bad++; $display("FAIL rst_xbp_pc got=%h exp=0", out_xbp_pc); end
    rst = 1'b1;
    alloc(5'd1, 1'b0, 1'b0, 32'h0);
    alloc(5'd2, 1'b0, 1'b0, 32'h4);
    cdb(4'd0, 32'h11, 1'b0, 32'h0);
    tick();
    total++; if (out_commit_reg !== 5'd1) begin bad++; $display("FAIL pre_rst_commit got=%0d exp=1", out_commit_reg); end
    total++; if (out_alloc_rob !== 4'd2) begin bad++; $display("FAIL pre_rst_tail got=%0d exp=2", out_alloc_rob); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL midrst_commit_reg got=%0d exp=0", out_commit_reg); end
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL midrst_alloc_rob got=%0d exp=0", out_alloc_rob); end
    total++; if (out_xbp !== 1'b0) begin bad++; $display("FAIL midrst_xbp got=%0b exp=0", out_xbp); end
    total++; if (out_full !== 1'b0) begin bad++; $display("FAIL midrst_full got=%0b exp=0", out_full); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_inorder_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total++; if (out_alloc_rob !== 4'(i)) begin bad++; $display("FAIL io_tag%0d got=%0d exp=%0d", i, out_alloc_rob, i); end
      alloc(5'(i + 1), 1'b0, 1'b0, 32'h100 + 32'(4 * i));
    end
    cdb(4'd2, 32'h300, 1'b0, 32'h0);
    total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL io_early1 got=%0d exp=0", out_commit_reg); end
    cdb(4'd0, 32'h100, 1'b0, 32'h0);
    total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL io_early2 got=%0d exp=0", out_commit_reg); end
    cdb(4'd1, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_commit_reg !== 5'(i + 1)) begin bad++; $display("FAIL io_reg%0d got=%0d exp=%0d", i, out_commit_reg, i + 1); end
      total++; if (out_commit_rob !== 4'(i)) begin bad++; $display("FAIL io_rob%0d got=%0d exp=%0d", i, out_commit_rob, i); end
      total++; if (out_commit_value !== 32'h100 * 32'(i + 1)) begin bad++; $display("FAIL io_val%0d got=%h exp=%h", i, out_commit_value, 32'h100 * 32'(i + 1)); end
      tick();
    end
    total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL io_idle got=%0d exp=0", out_commit_reg); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      total++; if (out_full !== 1'b0) begin bad++; $display("FAIL fw_notfull%0d got=%0b exp=0", i, out_full); end
      alloc(5'(i + 1), 1'b0, 1'b0, 32'(i));
    end
    total++; if (out_full !== 1'b1) begin bad++; $display("FAIL fw_full got=%0b exp=1", out_full); end
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL fw_tailwrap got=%0d exp=0", out_alloc_rob); end
    alloc(5'd30, 1'b0, 1'b0, 32'hBAD);
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL fw_17th_tail got=%0d exp=0", out_alloc_rob); end
    total++; if (out_full !== 1'b1) begin bad++; $display("FAIL fw_17th_full got=%0b exp=1", out_full); end
    cdb(4'd0, 32'hAA, 1'b0, 32'h0);
    tick();
    total++; if (out_commit_reg !== 5'd1) begin bad++; $display("FAIL fw_commit_reg got=%0d exp=1", out_commit_reg); end
    total++; if (out_full !== 1'b0) begin bad++; $display("FAIL fw_after_commit got=%0b exp=0", out_full); end
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL fw_wrap_tag got=%0d exp=0", out_alloc_rob); end
    alloc(5'd20, 1'b0, 1'b0, 32'h40);
    total++; if (out_alloc_rob !== 4'd1) begin bad++; $display("FAIL fw_next_tail got=%0d exp=1", out_alloc_rob); end
    total++; if (out_full !== 1'b1) begin bad++; $display("FAIL fw_refull got=%0b exp=1", out_full); end
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 1), 1'b0, 1'b0, 32'(i));
    in_query_rob1 = 4'd5; in_query_rob2 = 4'd4;
    in_cdb_valid = 1'b1; in_cdb_rob = 4'd5; in_cdb_value = 32'hDEAD;
    #1;
    total++; if (out_query_rdy1 !== 1'b1) begin bad++; $display("FAIL q_byp_rdy got=%0b exp=1", out_query_rdy1); end
    total++; if (out_query_val1 !== 32'hDEAD) begin bad++; $display("FAIL q_byp_val got=%h exp=0000dead", out_query_val1); end
    total++; if (out_query_rdy2 !== 1'b0) begin bad++; $display("FAIL q_pending_rdy got=%0b exp=0", out_query_rdy2); end
    tick();
    in_cdb_valid = 1'b0; in_query_rob2 = 4'd5;
    #1;
    total++; if (out_query_rdy2 !== 1'b1) begin bad++; $display("FAIL q_stored_rdy got=%0b exp=1", out_query_rdy2); end
    total++; if (out_query_val2 !== 32'hDEAD) begin bad++; $display("FAIL q_stored_val got=%h exp=0000dead", out_query_val2); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd0, 1'b1, 1'b0, 32'h500);
    alloc(5'd4, 1'b0, 1'b0, 32'h504);
    alloc(5'd5, 1'b0, 1'b0, 32'h508);
    cdb(4'd0, 32'h0, 1'b1, 32'h1000);
    in_alloc_valid = 1'b1; in_alloc_dest_reg = 5'd9;
    cdb(4'd1, 32'h77, 1'b0, 32'h0);
    total++; if (out_xbp !== 1'b1) begin bad++; $display("FAIL mp_xbp got=%0b exp=1", out_xbp); end
    total++; if (out_xbp_pc !== 32'h1000) begin bad++; $display("FAIL mp_pc got=%h exp=00001000", out_xbp_pc); end
    total++; if (out_commit_rob !== 4'd0) begin bad++; $display("FAIL mp_commit_rob got=%0d exp=0", out_commit_rob); end
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL mp_tail_reset got=%0d exp=0", out_alloc_rob); end
    tick();
    in_alloc_valid = 1'b0;
    in_query_rob1 = 4'd1;
    #1;
    total++; if (out_xbp !== 1'b0) begin bad++; $display("FAIL mp_pulse got=%0b exp=0", out_xbp); end
    total++; if (out_alloc_rob !== 4'd0) begin bad++; $display("FAIL mp_alloc_blocked got=%0d exp=0", out_alloc_rob); end
    total++; if (out_query_rdy1 !== 1'b0) begin bad++; $display("FAIL mp_discard got=%0b exp=0", out_query_rdy1); end
    alloc(5'd0, 1'b1, 1'b1, 32'h2000);
    total++; if (out_alloc_rob !== 4'd1) begin bad++; $display("FAIL mp_new_tag got=%0d exp=1", out_alloc_rob); end
    cdb(4'd0, 32'h0, 1'b0, 32'h9999);
    tick();
    total++; if (out_xbp_pc !== 32'h2004) begin bad++; $display("FAIL mp_nt_pc got=%h exp=00002004", out_xbp_pc); end
    tick();
    alloc(5'd3, 1'b1, 1'b1, 32'h3000);
    cdb(4'd0, 32'h5, 1'b1, 32'h4000);
    tick();
    total++; if (out_xbp !== 1'b0) begin bad++; $display("FAIL mp_correct_silent got=%0b exp=0", out_xbp); end
    total++; if (out_commit_reg !== 5'd3) begin bad++; $display("FAIL mp_correct_commit got=%0d exp=3", out_commit_reg); end
    total++; if (out_alloc_rob !== 4'd1) begin bad++; $display("FAIL mp_correct_tail got=%0d exp=1", out_alloc_rob); end
  endtask

  task automatic test_freeze();
    do_reset();
    alloc(5'd8, 1'b0, 1'b0, 32'h0);
    alloc(5'd9, 1'b0, 1'b0, 32'h4);
    cdb(4'd1, 32'h90, 1'b0, 32'h0);
    cdb(4'd0, 32'h80, 1'b0, 32'h0);
    rdy = 1'b0;
    in_alloc_valid = 1'b1; in_alloc_dest_reg = 5'd12;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL fz_commit%0d got=%0d exp=0", i, out_commit_reg); end
      total++; if (out_alloc_rob !== 4'd2) begin bad++; $display("FAIL fz_tail%0d got=%0d exp=2", i, out_alloc_rob); end
    end
    in_alloc_valid = 1'b0;
    rdy = 1'b1;
    tick();
    total++; if (out_commit_reg !== 5'd8) begin bad++; $display("FAIL fz_resume0 got=%0d exp=8", out_commit_reg); end
    total++; if (out_commit_value !== 32'h80) begin bad++; $display("FAIL fz_resume0_val got=%h exp=00000080", out_commit_value); end
    tick();
    total++; if (out_commit_reg !== 5'd9) begin bad++; $display("FAIL fz_resume1 got=%0d exp=9", out_commit_reg); end
    total++; if (out_commit_rob !== 4'd1) begin bad++; $display("FAIL fz_resume1_rob got=%0d exp=1", out_commit_rob); end
    tick();
    total++; if (out_commit_reg !== 5'd0) begin bad++; $display("FAIL fz_drained got=%0d exp=0", out_commit_reg); end
  endtask

  initial begin
    test_reset();
    test_inorder_commit();
    test_full_wrap();
    test_query_bypass();
    test_mispredict();
    test_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
